verificar_pin: RTL and testbench

Consumes the `pinPac_t` packets produced by the keypad PIN assembler and acts as the lock controller. It compares each submitted 4-digit PIN against a stored password and drives the lock output. It also counts consecutive failures, enforces a timed lockout and supports changing the password while the lock is open.

---
 rtl/verificar_pin.sv | 146 ++++++++++++++
 tb/tb_verificar_pin.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verificar_pin.sv
// Lock controller: checks submitted 4-digit PINs against a stored password.
// Also tracks consecutive failures, runs a timed lockout and supports password reprogramming.
module verificar_pin #(
   parameter logic [15:0] SENHA_PADRAO   = 16'h1234,
   parameter int          MAX_TENTATIVAS = 3,
   parameter logic [31:0] TEMPO_ABERTO   = 32'd50_000_000,
   parameter logic [31:0] TEMPO_BLOQUEIO = 32'd500_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] pin_in,
   input  logic        prog_req,
   output logic        tranca_aberta,
   output logic        bloqueado,
   output logic        programando,
   output logic        ok_pulse,
   output logic        erro_pulse,
   output logic [3:0]  tentativas
);

   // pinPac_t layout: {status, digit1 (last entered), digit2, digit3, digit4 (first entered)}
   typedef struct packed {
      logic       status;
      logic [3:0] digit1;
      logic [3:0] digit2;
      logic [3:0] digit3;
      logic [3:0] digit4;
   } pinPac_t;

   localparam logic [1:0] TRANCADO    = 2'd0;
   localparam logic [1:0] ABERTO      = 2'd1;
   localparam logic [1:0] PROGRAMANDO = 2'd2;
   localparam logic [1:0] BLOQUEADO   = 2'd3;

   localparam logic [4:0]  MAX_T       = 5'(MAX_TENTATIVAS);
   localparam logic [31:0] RECARGA_AB  = TEMPO_ABERTO - 32'd1;
   localparam logic [31:0] RECARGA_BLQ = TEMPO_BLOQUEIO - 32'd1;

   pinPac_t     pin;
   logic [15:0] pin_valor;
   logic        incompleto;
   logic        expirou;
   logic [4:0]  tent_inc;

   logic [1:0]  state, state_n;
   logic [31:0] timer, timer_n;
   logic [15:0] senha, senha_n;
   logic [3:0]  tent_n;
   logic        ok_n, erro_n;

   assign pin        = pin_in;
   assign pin_valor  = {pin.digit4, pin.digit3, pin.digit2, pin.digit1};
   assign incompleto = (pin.digit1 == 4'hA) || (pin.digit2 == 4'hA) ||
                       (pin.digit3 == 4'hA) || (pin.digit4 == 4'hA);
   assign expirou    = (timer == 32'd0);
   assign tent_inc   = {1'b0, tentativas} + 5'd1;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_n = state;
      timer_n = expirou ? timer : timer - 32'd1;
      senha_n = senha;
      tent_n  = tentativas;
      ok_n    = 1'b0;
      erro_n  = 1'b0;

      case (state)
         TRANCADO: begin
            if (pin.status) begin
               if (incompleto) begin
                  erro_n = 1'b1;
               end else if (pin_valor == senha) begin
                  state_n = ABERTO;
                  timer_n = RECARGA_AB;
                  tent_n  = 4'd0;
                  ok_n    = 1'b1;
               end else begin
                  erro_n = 1'b1;
                  if (tent_inc >= MAX_T) begin
                     state_n = BLOQUEADO;
                     timer_n = RECARGA_BLQ;
                     tent_n  = 4'd0;
                  end else begin
                     tent_n = tent_inc[3:0];
                  end
               end
            end
         end

         ABERTO: begin
            // Reprogram request takes priority over the open window expiring.
            if (prog_req) begin
               state_n = PROGRAMANDO;
               timer_n = RECARGA_AB;
            end else if (expirou) begin
               state_n = TRANCADO;
            end
         end

         PROGRAMANDO: begin
            if (expirou) begin
               state_n = TRANCADO;
            end else if (pin.status) begin
               if (incompleto) begin
                  erro_n = 1'b1;
               end else begin
                  senha_n = pin_valor;
                  ok_n    = 1'b1;
                  state_n = TRANCADO;
                  timer_n = 32'd0;
               end
            end
         end

         BLOQUEADO: begin
            if (expirou) state_n = TRANCADO;
         end

         default: state_n = TRANCADO;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= TRANCADO;
         timer      <= 32'd0;
         senha      <= SENHA_PADRAO;
         tentativas <= 4'd0;
         ok_pulse   <= 1'b0;
         erro_pulse <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         senha      <= senha_n;
         tentativas <= tent_n;
         ok_pulse   <= ok_n;
         erro_pulse <= erro_n;
      end
   end

   assign tranca_aberta = (state == ABERTO);
   assign programando   = (state == PROGRAMANDO);
   assign bloqueado     = (state == BLOQUEADO);

endmodule

// File: tb/tb_verificar_pin.sv
// Bench for verificar_pin: vector table, directed multi-cycle sequences,
// then random stimulus compared against an absolute-deadline reference model.
module tb_verificar_pin;

   localparam int TA  = 8;
   localparam int TB  = 16;
   localparam int MAX = 3;

   logic        clk;
   logic        rst;
   logic [16:0] pin_in;
   logic        prog_req;
   logic        tranca_aberta, bloqueado, programando, ok_pulse, erro_pulse;
   logic [3:0]  tentativas;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   verificar_pin #(
      .SENHA_PADRAO  (16'h1234),
      .MAX_TENTATIVAS(MAX),
      .TEMPO_ABERTO  (32'(TA)),
      .TEMPO_BLOQUEIO(32'(TB))
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pin_in       (pin_in),
      .prog_req     (prog_req),
      .tranca_aberta(tranca_aberta),
      .bloqueado    (bloqueado),
      .programando  (programando),
      .ok_pulse     (ok_pulse),
      .erro_pulse   (erro_pulse),
      .tentativas   (tentativas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [15:0] digits;   // first entered in the top nibble
      logic        status;
      logic        prog;
      logic        exp_ok;
      logic        exp_erro;
      logic        exp_aberto;
      logic [3:0]  exp_tent;
   } vec_t;

   typedef enum {M_LOCKED, M_OPEN, M_PROG, M_BLOCK} mode_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [16:0] mk(input logic st, input logic [15:0] v);
      return {st, v[3:0], v[7:4], v[11:8], v[15:12]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic submit(input logic [15:0] v);
      pin_in = mk(1'b1, v);
      tick();
      pin_in = mk(1'b0, 16'h0000);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      pin_in   = '0;
      prog_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check({name, "_aberto"}, 32'(tranca_aberta), 0);
      check({name, "_bloq"},   32'(bloqueado), 0);
      check({name, "_prog"},   32'(programando), 0);
      check({name, "_ok"},     32'(ok_pulse), 0);
      check({name, "_erro"},   32'(erro_pulse), 0);
      check({name, "_tent"},   32'(tentativas), 0);
   endtask

   vec_t vecs[7];

   // reference model state
   mode_t       m_mode;
   int          m_until;
   logic [15:0] m_senha;
   int          m_tent;
   logic        m_ok, m_erro;

   function automatic bit has_blank(input logic [15:0] v);
      for (int i = 0; i < 4; i++)
         if (((v >> (4 * i)) & 16'hF) == 16'hA) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input int k, input logic st, input logic [15:0] v, input logic pr);
      m_ok   = 1'b0;
      m_erro = 1'b0;
      case (m_mode)
         M_LOCKED: if (st) begin
            if (has_blank(v)) m_erro = 1'b1;
            else if (v == m_senha) begin
               m_mode = M_OPEN; m_until = k + TA; m_ok = 1'b1; m_tent = 0;
            end else begin
               m_erro = 1'b1;
               m_tent++;
               if (m_tent == MAX) begin
                  m_mode = M_BLOCK; m_until = k + TB; m_tent = 0;
               end
            end
         end
         M_OPEN: begin
            if (pr) begin
               m_mode = M_PROG; m_until = k + TA;
            end else if (k == m_until) m_mode = M_LOCKED;
         end
         M_PROG: begin
            if (k == m_until) m_mode = M_LOCKED;
            else if (st) begin
               if (has_blank(v)) m_erro = 1'b1;
               else begin
                  m_senha = v; m_ok = 1'b1; m_mode = M_LOCKED;
               end
            end
         end
         M_BLOCK: if (k == m_until) m_mode = M_LOCKED;
      endcase
   endtask

   initial begin
      int count;

      vecs[0] = '{16'h9999, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      vecs[1] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
      vecs[2] = '{16'hAA34, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      vecs[3] = '{16'h999A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      vecs[4] = '{16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
      vecs[5] = '{16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
      vecs[6] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};

      // Reset state
      do_reset();
      check_idle("reset");

      // Vector table
      foreach (vecs[i]) begin
         pin_in   = mk(vecs[i].status, vecs[i].digits);
         prog_req = vecs[i].prog;
         tick();
         check($sformatf("vec%0d_ok", i),     32'(ok_pulse),      32'(vecs[i].exp_ok));
         check($sformatf("vec%0d_erro", i),   32'(erro_pulse),    32'(vecs[i].exp_erro));
         check($sformatf("vec%0d_aberto", i), 32'(tranca_aberta), 32'(vecs[i].exp_aberto));
         check($sformatf("vec%0d_tent", i),   32'(tentativas),    32'(vecs[i].exp_tent));
      end
      pin_in   = '0;
      prog_req = 1'b0;

      // Correct PIN: open window length
      do_reset();
      submit(16'h1234);
      check("open_ok", 32'(ok_pulse), 1);
      check("open_aberto", 32'(tranca_aberta), 1);
      count = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i == 0) check("open_ok_width", 32'(ok_pulse), 0);
         if (!tranca_aberta) break;
         count++;
      end
      check("open_len", 32'(count), TA);
      check("open_tent", 32'(tentativas), 0);

      // Wrong PIN three times -> lockout
      do_reset();
      submit(16'h9999);
      check("wrong1_erro", 32'(erro_pulse), 1);
      check("wrong1_tent", 32'(tentativas), 1);
      submit(16'h9999);
      check("wrong2_erro", 32'(erro_pulse), 1);
      check("wrong2_tent", 32'(tentativas), 2);
      submit(16'h9999);
      check("wrong3_erro", 32'(erro_pulse), 1);
      check("wrong3_bloq", 32'(bloqueado), 1);
      check("wrong3_tent", 32'(tentativas), 0);
      count = 1;
      for (int i = 0; i < 60; i++) begin
         if (i == 4) pin_in = mk(1'b1, 16'h1234);
         tick();
         pin_in = '0;
         if (i == 4) begin
            check("bloq_ignore_ok", 32'(ok_pulse), 0);
            check("bloq_ignore_erro", 32'(erro_pulse), 0);
            check("bloq_ignore_aberto", 32'(tranca_aberta), 0);
         end
         if (!bloqueado) break;
         count++;
      end
      check("bloq_len", 32'(count), TB);
      submit(16'h1234);
      check("after_bloq_ok", 32'(ok_pulse), 1);

      // Reprogram then reset mid-operation
      do_reset();
      submit(16'h1234);
      prog_req = 1'b1;
      tick();
      prog_req = 1'b0;
      check("prog_enter", 32'(programando), 1);
      check("prog_aberto", 32'(tranca_aberta), 0);
      submit(16'h56A8);
      check("prog_incomplete_erro", 32'(erro_pulse), 1);
      check("prog_incomplete_stay", 32'(programando), 1);
      submit(16'h5678);
      check("prog_store_ok", 32'(ok_pulse), 1);
      check("prog_store_locked", 32'(programando | tranca_aberta), 0);
      submit(16'h1234);
      check("old_pin_erro", 32'(erro_pulse), 1);
      submit(16'h5678);
      check("new_pin_ok", 32'(ok_pulse), 1);
      check("new_pin_aberto", 32'(tranca_aberta), 1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_idle("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      submit(16'h1234);
      check("post_rst_ok", 32'(ok_pulse), 1);
      check("post_rst_aberto", 32'(tranca_aberta), 1);

      // Programming timeout keeps old password
      do_reset();
      submit(16'h1234);
      prog_req = 1'b1;
      tick();
      prog_req = 1'b0;
      count = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!programando) break;
         count++;
      end
      check("prog_timeout_len", 32'(count), TA);
      check("prog_timeout_aberto", 32'(tranca_aberta), 0);
      submit(16'h1234);
      check("prog_timeout_senha", 32'(ok_pulse), 1);

      // Random stimulus against the reference model
      do_reset();
      m_mode = M_LOCKED; m_until = 0; m_senha = 16'h1234; m_tent = 0;
      for (int n = 0; n < 3000; n++) begin
         logic        st, pr;
         logic [15:0] v;
         int          sel;
         st  = ($urandom_range(0, 3) == 0);
         pr  = ($urandom_range(0, 5) == 0);
         sel = $urandom_range(0, 3);
         case (sel)
            0: v = m_senha;
            1: v = 16'h1234;
            2: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            default: v = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)),
                          4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
         endcase
         pin_in   = mk(st, v);
         prog_req = pr;
         tick();
         model_step(cyc, st, v, pr);
         check("rnd_aberto", 32'(tranca_aberta), 32'(m_mode == M_OPEN));
         check("rnd_prog",   32'(programando),   32'(m_mode == M_PROG));
         check("rnd_bloq",   32'(bloqueado),     32'(m_mode == M_BLOCK));
         check("rnd_ok",     32'(ok_pulse),      32'(m_ok));
         check("rnd_erro",   32'(erro_pulse),    32'(m_erro));
         check("rnd_tent",   32'(tentativas),    32'(m_tent));
      end
      pin_in   = '0;
      prog_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
